instr_fetch_queue: RTL

//   Fetch stage directly upstream of the decode/control stage. Holds the PC and fetches 32-bit

---
 rtl/instr_fetch_queue.sv | 84 ++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC holder, single-outstanding imem fetch and DEPTH-entry instruction FIFO with redirect flush
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [6:0]  Op_Code,
  output logic [9:0]  funct
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc, drop_addr;
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_n;
  logic push, pop;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready && !redirect;
  assign push = state == REQ && imem_ack && !redirect;
  assign count_n = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign imem_req = !rst && state != IDLE;
  assign imem_addr = state == DROP ? drop_addr : fetch_pc;
  assign out_instr = out_valid ? mem_instr[rd_ptr] : 32'h0000_0013;
  assign out_pc = out_valid ? mem_pc[rd_ptr] : 32'h0;
  assign Op_Code = out_instr[6:0];
  assign funct = {out_instr[31:25], out_instr[14:12]};
  always_comb begin
    state_n = state;
    if (redirect)
      state_n = (state != IDLE && !imem_ack) ? DROP : REQ;
    else if (state == IDLE)
      state_n = count < FULL ? REQ : IDLE;
    else if (state == REQ)
      state_n = (imem_ack && count_n >= FULL) ? IDLE : REQ;
    else
      state_n = imem_ack ? REQ : DROP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      drop_addr <= RESET_PC;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_n;
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        if (state == REQ && !imem_ack) drop_addr <= fetch_pc;
      end else begin
        count <= count_n;
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr] <= fetch_pc;
    end
  end
endmodule
